// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    // Sequencer states: normal flow, waiting on data memory, one-cycle timeout recovery.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } hz_state_e;

    // Default number of MEM_WAIT cycles tolerated before declaring a memory fault.
    localparam int DEFAULT_MEM_TIMEOUT = 15;

    // Pipeline control bundle driven by the sequencer.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
        logic dmem_req;
    } pipe_ctl_t;

    // Free-flowing pipeline: every register advances, no bubbles, no memory request.
    function automatic pipe_ctl_t ctl_flow();
        pipe_ctl_t c;
        c = '0;
        c.pc_en     = 1'b1;
        c.if_id_en  = 1'b1;
        c.id_ex_en  = 1'b1;
        c.ex_mem_en = 1'b1;
        c.mem_wb_en = 1'b1;
        return c;
    endfunction

    // Memory stall: everything up to EX/MEM holds, a bubble goes into MEM/WB.
    function automatic pipe_ctl_t ctl_mem_freeze();
        pipe_ctl_t c;
        c = '0;
        c.mem_wb_en    = 1'b1;
        c.mem_wb_flush = 1'b1;
        c.dmem_req     = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination
// feeds either source operand of the instruction currently in ID.
module load_use_detect
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_data_re,
    input  logic       ex_reg_file_we,
    input  logic [4:0] ex_reg_file_rd,
    output logic       hazard
);

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    always_comb begin
        hazard = ex_data_re && ex_reg_file_we && (ex_reg_file_rd != 5'd0) &&
                 ((ex_reg_file_rd == id_rs1) || (ex_reg_file_rd == id_rs2));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch redirect flushes,
// data-memory wait states with timeout, and a stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        ex_data_re,
    input  logic        ex_reg_file_we,
    input  logic [4:0]  ex_reg_file_rd,
    input  logic        ex_redirect,
    input  logic        mem_data_mem_re,
    input  logic        mem_data_mem_we,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic        mem_fault,
    output logic [31:0] stall_cycles
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    hz_state_e        state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [31:0]      stall_cycles_reg;
    logic             mem_fault_reg;
    logic             load_use;
    logic             mem_access;
    pipe_ctl_t        ctl;

    load_use_detect u_load_use_detect (
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .ex_data_re     (ex_data_re),
        .ex_reg_file_we (ex_reg_file_we),
        .ex_reg_file_rd (ex_reg_file_rd),
        .hazard         (load_use)
    );

    assign mem_access = mem_data_mem_re | mem_data_mem_we;

    // State, wait counter and fault pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            wait_cnt_reg  <= '0;
            mem_fault_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            mem_fault_reg <= (state_next == ST_FAULT);
        end
    end

    // Next-state and pipeline controls; reset forces every control low so an
    // in-flight memory request is dropped without waiting for a clock edge.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        ctl           = '0;
        if (!rst) begin
            unique case (state_reg)
                ST_RUN: begin
                    if (mem_access && !dmem_ready) begin
                        // MEM stall wins over everything: EX is frozen, so any
                        // redirect or load-use is reconsidered after the wait.
                        ctl           = ctl_mem_freeze();
                        state_next    = ST_MEM_WAIT;
                        wait_cnt_next = '0;
                    end else begin
                        ctl          = ctl_flow();
                        ctl.dmem_req = mem_access;
                        if (ex_redirect) begin
                            // The squashed younger instructions make the load-use moot.
                            ctl.if_id_flush = 1'b1;
                            ctl.id_ex_flush = 1'b1;
                        end else if (load_use) begin
                            ctl.pc_en       = 1'b0;
                            ctl.if_id_en    = 1'b0;
                            ctl.id_ex_flush = 1'b1;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready) begin
                        // Ready beats a timeout landing in the same cycle.
                        ctl          = ctl_flow();
                        ctl.dmem_req = 1'b1;
                        state_next   = ST_RUN;
                    end else begin
                        ctl = ctl_mem_freeze();
                        if (wait_cnt_reg == CNT_LAST) begin
                            state_next = ST_FAULT;
                        end else begin
                            wait_cnt_next = wait_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    // Squash the whole pipe but keep fetching so recovery proceeds.
                    ctl.pc_en        = 1'b1;
                    ctl.if_id_flush  = 1'b1;
                    ctl.id_ex_flush  = 1'b1;
                    ctl.ex_mem_flush = 1'b1;
                    ctl.mem_wb_flush = 1'b1;
                    state_next       = ST_RUN;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    // Stall counter: counts every cycle the PC is held, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_reg <= '0;
        end else if (!ctl.pc_en) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    assign pc_en        = ctl.pc_en;
    assign if_id_en     = ctl.if_id_en;
    assign id_ex_en     = ctl.id_ex_en;
    assign ex_mem_en    = ctl.ex_mem_en;
    assign mem_wb_en    = ctl.mem_wb_en;
    assign if_id_flush  = ctl.if_id_flush;
    assign id_ex_flush  = ctl.id_ex_flush;
    assign ex_mem_flush = ctl.ex_mem_flush;
    assign mem_wb_flush = ctl.mem_wb_flush;
    assign dmem_req     = ctl.dmem_req;
    assign mem_fault    = mem_fault_reg;
    assign stall_cycles = stall_cycles_reg;

endmodule
